// File: rtl/ysyx_23060061_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : ysyx_23060061_lsu                                                  |
// | Brief  : Multi-cycle load/store unit with an AXI4-Lite master port.        |
// |          One access in flight; byte-lane steering, misalign/illegal checks, |
// |          bus error reporting and a saturating per-access latency counter.  |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module ysyx_23060061_lsu #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  parameter int LAT_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_op,
  input  logic [1:0]          in_size,
  input  logic                in_unsigned,
  input  logic [ADDR_W-1:0]   in_addr,
  input  logic [XLEN-1:0]     in_wdata,
  output logic [ADDR_W-1:0]   araddr,
  output logic                arvalid,
  input  logic                arready,
  input  logic [XLEN-1:0]     rdata,
  input  logic [1:0]          rresp,
  input  logic                rvalid,
  output logic                rready,
  output logic [ADDR_W-1:0]   awaddr,
  output logic                awvalid,
  input  logic                awready,
  output logic [XLEN-1:0]     wdata,
  output logic [XLEN/8-1:0]   wstrb,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_rdata,
  output logic [1:0]          out_err,
  output logic [LAT_W-1:0]    out_lat
);

  localparam int NBYTE = XLEN / 8;
  localparam int OFFW  = $clog2(NBYTE);

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_ALIGN = 2'b01;
  localparam logic [1:0] ERR_BUS   = 2'b10;
  localparam logic [1:0] ERR_ILL   = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RADDR = 3'd1,
    RDATA = 3'd2,
    WREQ  = 3'd3,
    WRESP = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [XLEN-1:0]     wdata_q, wdata_d;
  logic [NBYTE-1:0]    wstrb_q, wstrb_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic [XLEN-1:0]     rdata_q, rdata_d;
  logic [1:0]          err_q, err_d;
  logic [LAT_W-1:0]    lat_q, lat_d;

  logic [OFFW-1:0]     in_off, off, mis_mask;
  logic [7:0]          strb_base;
  logic [XLEN-1:0]     lane, ext;
  logic                illegal, misaligned, aw_hs, w_hs;

  assign in_off = in_addr[OFFW-1:0];
  assign off    = addr_q[OFFW-1:0];

  // Outputs are decoded from state; only registered payload leaves the block.
  assign in_ready  = (state_q == IDLE) && rst;
  assign arvalid   = (state_q == RADDR);
  assign rready    = (state_q == RDATA);
  assign awvalid   = (state_q == WREQ) && !aw_done_q;
  assign wvalid    = (state_q == WREQ) && !w_done_q;
  assign bready    = (state_q == WRESP);
  assign out_valid = (state_q == DONE);
  assign araddr    = addr_q;
  assign awaddr    = addr_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign out_rdata = rdata_q;
  assign out_err   = err_q;
  assign out_lat   = lat_q;
  assign aw_hs     = awvalid && awready;
  assign w_hs      = wvalid && wready;

  // Request decode: legality, alignment and store lane steering.
  always_comb begin
    illegal  = !((in_op == 2'b10) || (in_op == 2'b01)) || ((in_size == 2'd3) && (XLEN != 64));
    mis_mask = OFFW'((4'd1 << in_size) - 4'd1);
    misaligned = (in_off & mis_mask) != '0;
    case (in_size)
      2'd0:    strb_base = 8'h01;
      2'd1:    strb_base = 8'h03;
      2'd2:    strb_base = 8'h0F;
      default: strb_base = 8'hFF;
    endcase
  end

  // Load lane extraction followed by sign/zero extension.
  always_comb begin
    lane = rdata >> {off, 3'b000};
    case (size_q)
      2'd0:    ext = uns_q ? XLEN'(lane[7:0])  : XLEN'($signed(lane[7:0]));
      2'd1:    ext = uns_q ? XLEN'(lane[15:0]) : XLEN'($signed(lane[15:0]));
      2'd2:    ext = uns_q ? XLEN'(lane[31:0]) : XLEN'($signed(lane[31:0]));
      default: ext = lane;
    endcase
  end

  // Next-state and payload update for the access sequencer.
  always_comb begin
    state_d   = state_q;
    size_d    = size_q;
    uns_d     = uns_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    lat_d     = lat_q;
    if ((state_q != IDLE) && (state_q != DONE) && (lat_q != '1)) begin
      lat_d = lat_q + 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          size_d    = in_size;
          uns_d     = in_unsigned;
          addr_d    = in_addr;
          wdata_d   = in_wdata << {in_off, 3'b000};
          wstrb_d   = NBYTE'(strb_base) << in_off;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          rdata_d   = '0;
          err_d     = ERR_OK;
          lat_d     = LAT_W'(1);
          if (illegal) begin
            err_d   = ERR_ILL;
            state_d = DONE;
          end else if (misaligned) begin
            err_d   = ERR_ALIGN;
            state_d = DONE;
          end else if (in_op == 2'b10) begin
            state_d = RADDR;
          end else begin
            state_d = WREQ;
          end
        end
      end
      RADDR: begin
        if (arready) state_d = RDATA;
      end
      RDATA: begin
        if (rvalid) begin
          if (rresp != 2'b00) begin
            err_d = ERR_BUS;
          end else begin
            rdata_d = ext;
          end
          state_d = DONE;
        end
      end
      WREQ: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = WRESP;
      end
      WRESP: begin
        if (bvalid) begin
          if (bresp != 2'b00) err_d = ERR_BUS;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and payload registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      size_q    <= '0;
      uns_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= '0;
      lat_q     <= '0;
    end else begin
      state_q   <= state_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      lat_q     <= lat_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_23060061_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_ysyx_23060061_lsu                                              |
// | Brief  : Directed self-checking bench for the AXI4-Lite load/store unit.   |
// | Rev    : 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module tb_ysyx_23060061_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [1:0]  in_op, in_size;
  logic        in_unsigned;
  logic [31:0] in_addr, in_wdata;
  logic [31:0] araddr;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;
  logic [31:0] awaddr;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic        out_valid, out_ready;
  logic [31:0] out_rdata;
  logic [1:0]  out_err;
  logic [7:0]  out_lat;

  int checks   = 0;
  int failures = 0;

  ysyx_23060061_lsu #(.XLEN(32), .ADDR_W(32), .LAT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_size(in_size),
    .in_unsigned(in_unsigned), .in_addr(in_addr), .in_wdata(in_wdata),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
    .out_err(out_err), .out_lat(out_lat)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [1:0] op, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd);
    int n;
    in_op = op; in_size = size; in_unsigned = uns; in_addr = addr; in_wdata = wd;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    if (n >= 20) chk("accept_timeout", {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
  endtask

  // Serve one read: immediate arready, then one beat of read data.
  task automatic serve_read(input logic [31:0] d, input logic [1:0] resp);
    int n;
    n = 0;
    while (!arvalid && n < 20) begin tick(); n++; end
    if (n >= 20) chk("ar_timeout", {63'd0, arvalid}, 64'd1);
    arready = 1'b1; tick(); arready = 1'b0;
    n = 0;
    while (!rready && n < 20) begin tick(); n++; end
    if (n >= 20) chk("r_timeout", {63'd0, rready}, 64'd1);
    rdata = d; rresp = resp; rvalid = 1'b1; tick();
    rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
  endtask

  task automatic release_result();
    out_ready = 1'b1; tick(); out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_op = 2'b00; in_size = 2'd0; in_unsigned = 1'b0;
    in_addr = 32'h0; in_wdata = 32'h0; arready = 1'b0; rdata = 32'h0; rresp = 2'b00;
    rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bresp = 2'b00; bvalid = 1'b0;
    out_ready = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_in_ready",  {63'd0, in_ready},  64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_valids",    {60'd0, arvalid, awvalid, wvalid, rready}, 64'd0);
    chk("rst_out",       {22'd0, out_rdata, out_err, out_lat}, 64'd0);
    rst = 1'b1;
    #1;
    chk("idle_in_ready", {63'd0, in_ready}, 64'd1);

    // lb at 0x80000003 -> sign-extended 0x80
    accept(2'b10, 2'd0, 1'b0, 32'h8000_0003, 32'h0);
    chk("lb_araddr", {32'd0, araddr}, 64'h8000_0003);
    serve_read(32'h80FF_1234, 2'b00);
    chk("lb_out_valid", {63'd0, out_valid}, 64'd1);
    chk("lb_rdata", {32'd0, out_rdata}, 64'hFFFF_FF80);
    chk("lb_err", {62'd0, out_err}, 64'd0);
    chk("lb_lat", {56'd0, out_lat}, 64'd3);
    release_result();
    chk("lb_back_idle", {62'd0, in_ready, out_valid}, 64'd2);

    // lhu at 0x80000002 -> upper half zero-extended
    accept(2'b10, 2'd1, 1'b1, 32'h8000_0002, 32'h0);
    serve_read(32'h80FF_1234, 2'b00);
    chk("lhu_rdata", {32'd0, out_rdata}, 64'h0000_80FF);
    release_result();

    // sb 0xAB at 0x80000001; awready two cycles before wready
    accept(2'b01, 2'd0, 1'b0, 32'h8000_0001, 32'h0000_00AB);
    chk("sb_valids", {62'd0, awvalid, wvalid}, 64'd3);
    chk("sb_awaddr", {32'd0, awaddr}, 64'h8000_0001);
    chk("sb_wdata", {32'd0, wdata}, 64'h0000_AB00);
    chk("sb_wstrb", {60'd0, wstrb}, 64'h2);
    awready = 1'b1; tick(); awready = 1'b0;
    chk("sb_aw_dropped", {62'd0, awvalid, wvalid}, 64'd1);
    tick();
    chk("sb_w_held", {62'd0, awvalid, wvalid}, 64'd1);
    chk("sb_wdata_stable", {32'd0, wdata}, 64'h0000_AB00);
    wready = 1'b1; tick(); wready = 1'b0;
    chk("sb_wresp", {61'd0, awvalid, wvalid, bready}, 64'd1);
    bvalid = 1'b1; bresp = 2'b00; tick(); bvalid = 1'b0;
    chk("sb_done", {61'd0, out_valid, out_err}, 64'h4);
    chk("sb_rdata_zero", {32'd0, out_rdata}, 64'd0);
    chk("sb_lat", {56'd0, out_lat}, 64'd5);
    release_result();

    // sh 0x1234 at 0x80000002 with both handshakes in the same cycle
    accept(2'b01, 2'd1, 1'b0, 32'h8000_0002, 32'h0000_1234);
    chk("sh_wdata", {32'd0, wdata}, 64'h1234_0000);
    chk("sh_wstrb", {60'd0, wstrb}, 64'hC);
    awready = 1'b1; wready = 1'b1; tick(); awready = 1'b0; wready = 1'b0;
    chk("sh_wresp", {61'd0, awvalid, wvalid, bready}, 64'd1);
    bvalid = 1'b1; tick(); bvalid = 1'b0;
    chk("sh_err", {61'd0, out_valid, out_err}, 64'h4);
    release_result();

    // Misaligned lw: no bus activity, latency 1
    accept(2'b10, 2'd2, 1'b0, 32'h8000_0002, 32'h0);
    chk("mis_arvalid", {63'd0, arvalid}, 64'd0);
    chk("mis_err", {61'd0, out_valid, out_err}, 64'h5);
    chk("mis_lat", {56'd0, out_lat}, 64'd1);
    release_result();

    // Illegal size and illegal op
    accept(2'b10, 2'd3, 1'b0, 32'h8000_0000, 32'h0);
    chk("ill_size", {61'd0, out_valid, out_err}, 64'h7);
    chk("ill_size_ar", {63'd0, arvalid}, 64'd0);
    release_result();
    accept(2'b11, 2'd0, 1'b0, 32'h8000_0000, 32'h0);
    chk("ill_op", {61'd0, out_valid, out_err}, 64'h7);
    release_result();

    // Bus error on load, result held while WB stalls
    accept(2'b10, 2'd2, 1'b0, 32'h8000_0008, 32'h0);
    serve_read(32'h1234_5678, 2'b10);
    for (int i = 0; i < 5; i++) begin
      chk("berr_hold", {29'd0, out_valid, in_ready, out_err, out_rdata}, {29'd0, 1'b1, 1'b0, 2'b10, 32'h0});
      tick();
    end
    release_result();

    // Reset while in RDATA abandons the access
    accept(2'b10, 2'd2, 1'b0, 32'h8000_0000, 32'h0);
    arready = 1'b1; tick(); arready = 1'b0;
    chk("pre_rst_rready", {63'd0, rready}, 64'd1);
    rst = 1'b0; tick();
    chk("mid_rst", {60'd0, arvalid, rready, out_valid, in_ready}, 64'd0);
    rst = 1'b1; #1;
    accept(2'b10, 2'd2, 1'b0, 32'h8000_0004, 32'h0);
    serve_read(32'hDEAD_BEEF, 2'b00);
    chk("post_rst_lw", {30'd0, out_err, out_rdata}, 64'hDEAD_BEEF);
    release_result();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
